// File: rtl/ifetch_warp_select.sv
// Fetch-front warp selector: one PC per warp, round-robin pick of an
// eligible warp per cycle, registered valid/stall request to the L1I tag stage.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   warp_enable             per-warp run enable
//   ift_stall               tag stage cannot accept; hold the request
//   miss_valid/_warp_idx/_pc  L1I miss: park warp, rewind its PC
//   fill_valid/_warp_idx    line fill done: wake warp
//   redirect_valid/_warp_idx/_pc  branch/rollback PC override
//   ift_valid/_warp_idx/_pc/_addr  registered fetch request
//
// Optional feature: define IFETCH_WARP_SELECT_PERF_EN to add the
// perf_fetch_count / perf_idle_count outputs.
module ifetch_warp_select #(
    parameter int          NUM_WARPS      = 4,
    parameter int          WARP_IDX_WIDTH = 2,
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_WARPS-1:0]      warp_enable,
    input  logic                      ift_stall,
    input  logic                      miss_valid,
    input  logic [WARP_IDX_WIDTH-1:0] miss_warp_idx,
    input  logic [31:0]               miss_pc,
    input  logic                      fill_valid,
    input  logic [WARP_IDX_WIDTH-1:0] fill_warp_idx,
    input  logic                      redirect_valid,
    input  logic [WARP_IDX_WIDTH-1:0] redirect_warp_idx,
    input  logic [31:0]               redirect_pc,
    output logic                      ift_valid,
    output logic [WARP_IDX_WIDTH-1:0] ift_warp_idx,
    output logic [31:0]               ift_pc,
    output logic [31:0]               ift_addr
`ifdef IFETCH_WARP_SELECT_PERF_EN
    ,
    output logic [31:0]               perf_fetch_count,
    output logic [31:0]               perf_idle_count
`endif
);

    logic [31:0]               pc_q [NUM_WARPS];
    logic [31:0]               pc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]      waiting_q, waiting_d;
    logic [WARP_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                      ift_valid_q, ift_valid_d;
    logic [WARP_IDX_WIDTH-1:0] ift_warp_idx_q, ift_warp_idx_d;
    logic [31:0]               ift_pc_q, ift_pc_d;

    logic [NUM_WARPS-1:0]      eligible;
    logic                      grant_valid;
    logic [WARP_IDX_WIDTH-1:0] grant_idx;
    logic [WARP_IDX_WIDTH-1:0] cand;
    logic                      issue;
    logic                      idle;
    logic [31:0]               miss_pc_al;
    logic [31:0]               redirect_pc_al;

    assign miss_pc_al     = miss_pc & ~32'h3;
    assign redirect_pc_al = redirect_pc & ~32'h3;

    // A warp being missed or redirected this cycle has a stale PC; mask it.
    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = warp_enable[w] & ~waiting_q[w]
                & ~(miss_valid && (miss_warp_idx == WARP_IDX_WIDTH'(w)))
                & ~(redirect_valid && (redirect_warp_idx == WARP_IDX_WIDTH'(w)));
        end
    end

    // Round-robin: first eligible warp at or above rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand = rr_ptr_q + WARP_IDX_WIDTH'(i);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign issue = ~ift_stall & grant_valid;
    assign idle  = ~ift_stall & ~grant_valid;

    // Later assignments win: redirect > miss > increment on PC,
    // miss set > fill clear on waiting.
    always_comb begin
        pc_d           = pc_q;
        waiting_d      = waiting_q;
        rr_ptr_d       = rr_ptr_q;
        ift_valid_d    = ift_valid_q;
        ift_warp_idx_d = ift_warp_idx_q;
        ift_pc_d       = ift_pc_q;

        if (issue) begin
            ift_valid_d      = 1'b1;
            ift_warp_idx_d   = grant_idx;
            ift_pc_d         = pc_q[grant_idx];
            pc_d[grant_idx]  = pc_q[grant_idx] + 32'd4;
            rr_ptr_d         = grant_idx + 1'b1;
        end else if (idle) begin
            ift_valid_d = 1'b0;
        end

        if (fill_valid)
            waiting_d[fill_warp_idx] = 1'b0;
        if (miss_valid) begin
            waiting_d[miss_warp_idx] = 1'b1;
            pc_d[miss_warp_idx]      = miss_pc_al;
        end
        if (redirect_valid)
            pc_d[redirect_warp_idx] = redirect_pc_al;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++)
                pc_q[w] <= RESET_ADDR;
            waiting_q      <= '0;
            rr_ptr_q       <= '0;
            ift_valid_q    <= 1'b0;
            ift_warp_idx_q <= '0;
            ift_pc_q       <= RESET_ADDR;
        end else begin
            pc_q           <= pc_d;
            waiting_q      <= waiting_d;
            rr_ptr_q       <= rr_ptr_d;
            ift_valid_q    <= ift_valid_d;
            ift_warp_idx_q <= ift_warp_idx_d;
            ift_pc_q       <= ift_pc_d;
        end
    end

    assign ift_valid    = ift_valid_q;
    assign ift_warp_idx = ift_warp_idx_q;
    assign ift_pc       = ift_pc_q;
    assign ift_addr     = ift_pc_q;

`ifdef IFETCH_WARP_SELECT_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_idle_q, perf_idle_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, issue};
        perf_idle_d  = perf_idle_q + {31'd0, idle};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_q <= '0;
            perf_idle_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_idle_q  <= perf_idle_d;
        end
    end

    assign perf_fetch_count = perf_fetch_q;
    assign perf_idle_count  = perf_idle_q;
`endif

endmodule

// File: tb/tb_ifetch_warp_select.sv
// Scoreboard bench for ifetch_warp_select: stimulus pushes expected
// (warp, pc) pairs; a negedge monitor pops on every accepted request.
module tb_ifetch_warp_select;

    typedef struct packed {
        logic [1:0]  w;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  warp_enable = '0;
    logic        ift_stall = 1'b0;
    logic        miss_valid = 1'b0;
    logic [1:0]  miss_warp_idx = '0;
    logic [31:0] miss_pc = '0;
    logic        fill_valid = 1'b0;
    logic [1:0]  fill_warp_idx = '0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_warp_idx = '0;
    logic [31:0] redirect_pc = '0;
    logic        ift_valid;
    logic [1:0]  ift_warp_idx;
    logic [31:0] ift_pc;
    logic [31:0] ift_addr;
`ifdef IFETCH_WARP_SELECT_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_idle_count;
    logic [31:0] idle_snap;
`endif

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ifetch_warp_select dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .warp_enable       (warp_enable),
        .ift_stall         (ift_stall),
        .miss_valid        (miss_valid),
        .miss_warp_idx     (miss_warp_idx),
        .miss_pc           (miss_pc),
        .fill_valid        (fill_valid),
        .fill_warp_idx     (fill_warp_idx),
        .redirect_valid    (redirect_valid),
        .redirect_warp_idx (redirect_warp_idx),
        .redirect_pc       (redirect_pc),
        .ift_valid         (ift_valid),
        .ift_warp_idx      (ift_warp_idx),
        .ift_pc            (ift_pc),
        .ift_addr          (ift_addr)
`ifdef IFETCH_WARP_SELECT_PERF_EN
        ,
        .perf_fetch_count  (perf_fetch_count),
        .perf_idle_count   (perf_idle_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] w, input logic [31:0] pc);
        exp_t e;
        e.w  = w;
        e.pc = pc;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserted between edges so the async path is exercised, outputs
    // checked before any clock edge arrives.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        warp_enable = '0;
        ift_stall = 1'b0;
        miss_valid = 1'b0;
        fill_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_valid", {31'd0, ift_valid}, 32'd0);
        chk("rst_warp", {30'd0, ift_warp_idx}, 32'd0);
        chk("rst_pc", ift_pc, 32'd0);
        chk("rst_addr", ift_addr, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: a request is consumed when valid and not stalled at the edge.
    always @(negedge clk) begin
        if (reset_n && ift_valid && !ift_stall) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_req: got w%0d pc %h, none expected",
                         ift_warp_idx, ift_pc);
            end else begin
                e = q.pop_front();
                if (ift_warp_idx !== e.w || ift_pc !== e.pc ||
                    ift_addr !== e.pc) begin
                    n_bad++;
                    $display("FAIL req: got w%0d pc %h addr %h expected w%0d pc %h",
                             ift_warp_idx, ift_pc, ift_addr, e.w, e.pc);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Round-robin from reset, with a 3-cycle stall on (w1,0).
        push(2'd0, 32'h0); push(2'd1, 32'h0); push(2'd2, 32'h0);
        push(2'd3, 32'h0); push(2'd0, 32'h4);
        warp_enable = 4'hF;
        tick();
        tick();
        ift_stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_valid", {31'd0, ift_valid}, 32'd1);
            chk("stall_warp", {30'd0, ift_warp_idx}, 32'd1);
            chk("stall_pc", ift_pc, 32'h0);
        end
        ift_stall = 1'b0;
        repeat (3) tick();
        warp_enable = '0;

        // Miss on warp 2, refetch 0x40 after fill.
        do_reset();
        push(2'd0, 32'h0); push(2'd1, 32'h0); push(2'd3, 32'h0);
        push(2'd0, 32'h4); push(2'd1, 32'h4); push(2'd3, 32'h4);
        push(2'd0, 32'h8); push(2'd1, 32'h8); push(2'd2, 32'h40);
        warp_enable = 4'hF;
        miss_valid = 1'b1;
        miss_warp_idx = 2'd2;
        miss_pc = 32'h40;
        tick();
        miss_valid = 1'b0;
        repeat (5) tick();
        fill_valid = 1'b1;
        fill_warp_idx = 2'd2;
        tick();
        fill_valid = 1'b0;
        tick();
        tick();
        warp_enable = '0;

        // Redirect beats miss on PC; warp still parked until fill.
        do_reset();
        push(2'd1, 32'h1000); push(2'd1, 32'h1004);
        warp_enable = 4'b0010;
        redirect_valid = 1'b1;
        redirect_warp_idx = 2'd1;
        redirect_pc = 32'h1003;
        miss_valid = 1'b1;
        miss_warp_idx = 2'd1;
        miss_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        miss_valid = 1'b0;
        chk("redir_masked", {31'd0, ift_valid}, 32'd0);
        tick();
        chk("redir_waiting", {31'd0, ift_valid}, 32'd0);
        fill_valid = 1'b1;
        fill_warp_idx = 2'd1;
        tick();
        chk("fill_edge_idle", {31'd0, ift_valid}, 32'd0);
        fill_valid = 1'b0;
        tick();
        tick();
        warp_enable = '0;

        // PC wrap at 2^32, then idle with no enabled warp.
        do_reset();
        push(2'd0, 32'hFFFF_FFFC); push(2'd0, 32'h0);
        warp_enable = 4'b0001;
        redirect_valid = 1'b1;
        redirect_warp_idx = 2'd0;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_masked", {31'd0, ift_valid}, 32'd0);
        tick();
        tick();
        warp_enable = '0;
`ifdef IFETCH_WARP_SELECT_PERF_EN
        idle_snap = perf_idle_count;
`endif
        tick();
        chk("idle_valid0", {31'd0, ift_valid}, 32'd0);
        tick();
        tick();
        chk("idle_valid2", {31'd0, ift_valid}, 32'd0);
`ifdef IFETCH_WARP_SELECT_PERF_EN
        chk("perf_idle", perf_idle_count, idle_snap + 32'd3);
        chk("perf_fetch", perf_fetch_count, 32'd2);
`endif

        tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
